// File: rtl/ddr2_avl_memtest.sv
`default_nettype none
// ============================================================================
// Module : ddr2_avl_memtest
// Brief  : Avalon-MM write/read-back pattern tester for the DDR2 UniPHY port.
// Rev    : 1.0 - initial release
// ============================================================================
module ddr2_avl_memtest #(
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter logic [23:0] END_ADDR   = 24'h000FFF,
  parameter int          MAX_OUTST  = 8,
  parameter int          TIMEOUT    = 4096
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        local_init_done,
  input  logic        local_cal_success,
  input  logic        local_cal_fail,
  input  logic        avl_ready,
  output logic        avl_burstbegin,
  output logic [23:0] avl_addr,
  output logic        avl_write_req,
  output logic        avl_read_req,
  output logic [63:0] avl_wdata,
  output logic        avl_size,
  input  logic        avl_rdata_valid,
  input  logic [63:0] avl_rdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [23:0] first_err_addr,
  output logic        cal_fail,
  output logic        timeout
);

  localparam int          TW          = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]  c_max_outst = 4'(MAX_OUTST);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_CAL = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_READ     = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  function automatic logic [63:0] pattern(input logic [23:0] a);
    pattern = {8'hA5, a, ~{8'hA5, a}};
  endfunction

  logic [2:0]    r_state, w_next_state;
  logic [23:0]   r_wa, r_ra, r_ca, r_first;
  logic [3:0]    r_outst, w_outst_nxt;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_err;
  logic          r_held, r_done, r_cal_fail, r_timeout;
  logic          w_wr_req, w_rd_req, w_wr_acc, w_rd_acc;
  logic          w_checking, w_ret, w_tmo_run, w_tmo_hit, w_mismatch;

  assign w_wr_req    = (r_state == S_WRITE);
  assign w_rd_req    = (r_state == S_READ) && (r_outst < c_max_outst);
  assign w_wr_acc    = w_wr_req && avl_ready;
  assign w_rd_acc    = w_rd_req && avl_ready;
  assign w_checking  = (r_state == S_READ) || (r_state == S_DRAIN);
  // Returns with nothing outstanding are stray and never reach the checker.
  assign w_ret       = w_checking && avl_rdata_valid && (r_outst != 4'd0);
  assign w_outst_nxt = r_outst + 4'(w_rd_acc) - 4'(w_ret);
  assign w_tmo_run   = w_checking && (r_outst != 4'd0) && !avl_rdata_valid;
  assign w_tmo_hit   = w_tmo_run && (r_tmo == c_tmo_last);
  assign w_mismatch  = w_ret && (avl_rdata != pattern(r_ca));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next_state = S_WAIT_CAL;
      S_WAIT_CAL: begin
        if (local_cal_fail)                              w_next_state = S_DONE;
        else if (local_init_done && local_cal_success)   w_next_state = S_WRITE;
      end
      S_WRITE:    if (w_wr_acc && (r_wa == END_ADDR)) w_next_state = S_READ;
      S_READ: begin
        if (w_tmo_hit)                            w_next_state = S_DONE;
        else if (w_rd_acc && (r_ra == END_ADDR))  w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_tmo_hit || (w_outst_nxt == 4'd0))   w_next_state = S_DONE;
      end
      S_DONE:     w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Command outputs are decoded from registers only, so reset drops them at once.
  always_comb begin
    avl_write_req  = w_wr_req;
    avl_read_req   = w_rd_req;
    avl_burstbegin = (w_wr_req || w_rd_req) && !r_held;
    avl_addr       = 24'd0;
    avl_wdata      = 64'd0;
    if (w_wr_req) begin
      avl_addr  = r_wa;
      avl_wdata = pattern(r_wa);
    end else if (w_rd_req) begin
      avl_addr  = r_ra;
    end
    avl_size       = 1'b1;
    busy           = (r_state != S_IDLE) && (r_state != S_DONE);
    done           = r_done;
    pass           = r_done && (r_err == 16'd0) && !r_cal_fail && !r_timeout;
    err_count      = r_err;
    first_err_addr = r_first;
    cal_fail       = r_cal_fail;
    timeout        = r_timeout;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wa       <= 24'd0;
      r_ra       <= 24'd0;
      r_ca       <= 24'd0;
      r_first    <= 24'd0;
      r_outst    <= 4'd0;
      r_tmo      <= '0;
      r_err      <= 16'd0;
      r_held     <= 1'b0;
      r_done     <= 1'b0;
      r_cal_fail <= 1'b0;
      r_timeout  <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_wa       <= START_ADDR;
      r_ra       <= START_ADDR;
      r_ca       <= START_ADDR;
      r_first    <= 24'd0;
      r_outst    <= 4'd0;
      r_tmo      <= '0;
      r_err      <= 16'd0;
      r_held     <= 1'b0;
      r_done     <= 1'b0;
      r_cal_fail <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      // A request left unaccepted is held, so the next cycle is not a new command.
      r_held  <= (w_wr_req || w_rd_req) && !avl_ready;
      r_outst <= w_outst_nxt;
      r_tmo   <= w_tmo_run ? r_tmo + 1'b1 : '0;
      if (w_wr_acc) r_wa <= r_wa + 24'd1;
      if (w_rd_acc) r_ra <= r_ra + 24'd1;
      if (w_ret)    r_ca <= r_ca + 24'd1;
      if (w_mismatch) begin
        if (r_err != 16'hFFFF) r_err   <= r_err + 16'd1;
        if (r_err == 16'd0)    r_first <= r_ca;
      end
      if ((r_state == S_WAIT_CAL) && local_cal_fail) r_cal_fail <= 1'b1;
      if (w_tmo_hit)                  r_timeout <= 1'b1;
      if (w_next_state == S_DONE)     r_done    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_avl_memtest.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr2_avl_memtest
// Brief  : Randomised self-checking bench with a behavioural memory and model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ddr2_avl_memtest;
  localparam int N = 16, LAT = 3, MAXO = 8, TMO = 64;

  logic        CLK = 1'b0, nRST = 1'b0, start = 1'b0;
  logic        local_init_done = 1'b1, local_cal_success = 1'b1, local_cal_fail = 1'b0;
  logic        avl_ready = 1'b1, avl_rdata_valid = 1'b0;
  logic [63:0] avl_rdata = 64'd0;
  logic        avl_burstbegin, avl_write_req, avl_read_req, avl_size;
  logic [23:0] avl_addr, first_err_addr;
  logic [63:0] avl_wdata;
  logic        busy, done, pass, cal_fail, timeout;
  logic [15:0] err_count;

  ddr2_avl_memtest #(
    .START_ADDR(24'h000000), .END_ADDR(24'd15), .MAX_OUTST(MAXO), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .nRST(nRST), .start(start),
    .local_init_done(local_init_done), .local_cal_success(local_cal_success),
    .local_cal_fail(local_cal_fail), .avl_ready(avl_ready),
    .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
    .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_wdata(avl_wdata), .avl_size(avl_size),
    .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .cal_fail(cal_fail), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [23:0] a);
    return {8'hA5, a, ~{8'hA5, a}};
  endfunction

  // Stimulus configuration, set by the control process between tests.
  int          stall_pct = 0;
  bit          noret = 1'b0, spur = 1'b0;
  logic [63:0] mask [N];

  // Behavioural model of one test run.
  typedef enum {P_IDLE, P_WAIT, P_WR, P_RD, P_DONE} ph_t;
  typedef struct packed { logic [31:0] due; logic [63:0] data; } rq_t;
  ph_t         ph = P_IDLE;
  int          n_wr = 0, n_rd = 0, n_ret = 0, outst = 0, idle_run = 0, cyc = 0;
  logic        m_done = 1'b0, m_cf = 1'b0, m_to = 1'b0, prev_stall = 1'b0;
  logic [15:0] m_err = 16'd0;
  logic [23:0] m_first = 24'd0, prev_addr = 24'd0;
  logic [63:0] mem [N];
  rq_t         q [$];
  int          bb_cnt = 0, wr_acc_cnt = 0, rd_acc_cnt = 0;

  always @(negedge CLK) begin : monitor
    logic exp_wr, exp_rd, acc_w, acc_r, ret;
    logic [23:0] exp_addr;
    cyc++;
    if (!nRST) begin
      ph = P_IDLE; m_done = 0; m_cf = 0; m_to = 0; m_err = 0; m_first = 0;
      n_wr = 0; n_rd = 0; n_ret = 0; outst = 0; idle_run = 0; prev_stall = 0;
      q.delete();
      avl_ready = 1'b1; avl_rdata_valid = 1'b0;
    end else begin
      exp_wr   = (ph == P_WR);
      exp_rd   = (ph == P_RD) && (n_rd < N) && (outst < MAXO);
      exp_addr = exp_wr ? 24'(n_wr) : (exp_rd ? 24'(n_rd) : 24'd0);
      check("write_req", 64'(avl_write_req), 64'(exp_wr));
      check("read_req", 64'(avl_read_req), 64'(exp_rd));
      check("addr", 64'(avl_addr), 64'(exp_addr));
      check("wdata", avl_wdata, exp_wr ? pat(exp_addr) : 64'd0);
      check("burstbegin", 64'(avl_burstbegin), 64'((exp_wr || exp_rd) && !prev_stall));
      if (prev_stall) check("stall_hold_addr", 64'(avl_addr), 64'(prev_addr));
      check("size", 64'(avl_size), 64'd1);
      check("busy", 64'(busy), 64'(ph == P_WAIT || ph == P_WR || ph == P_RD));
      check("done", 64'(done), 64'(m_done));
      check("pass", 64'(pass), 64'(m_done && m_err == 16'd0 && !m_cf && !m_to));
      check("err_count", 64'(err_count), 64'(m_err));
      check("first_err_addr", 64'(first_err_addr), 64'(m_first));
      check("cal_fail", 64'(cal_fail), 64'(m_cf));
      check("timeout", 64'(timeout), 64'(m_to));
      bb_cnt += int'(avl_burstbegin);

      // Memory side: stalls, in-order returns and stray strobes.
      avl_ready = ($urandom_range(99) >= 32'(stall_pct));
      if (!noret && q.size() > 0 && q[0].due <= 32'(cyc)) begin
        avl_rdata_valid = 1'b1;
        avl_rdata       = q[0].data;
        void'(q.pop_front());
      end else if (spur && outst == 0 && $urandom_range(3) == 0) begin
        avl_rdata_valid = 1'b1;
        avl_rdata       = {$urandom, $urandom};
      end else begin
        avl_rdata_valid = 1'b0;
        avl_rdata       = {$urandom, $urandom};
      end
      acc_w      = exp_wr && avl_ready;
      acc_r      = exp_rd && avl_ready;
      prev_stall = (exp_wr || exp_rd) && !avl_ready;
      prev_addr  = avl_addr;
      wr_acc_cnt += int'(acc_w);
      rd_acc_cnt += int'(acc_r);

      case (ph)
        P_IDLE: if (start) begin
          ph = P_WAIT; m_done = 0; m_cf = 0; m_to = 0; m_err = 0; m_first = 0;
          n_wr = 0; n_rd = 0; n_ret = 0; outst = 0; idle_run = 0; q.delete();
        end
        P_WAIT: begin
          if (local_cal_fail) begin m_cf = 1; m_done = 1; ph = P_DONE; end
          else if (local_init_done && local_cal_success) ph = P_WR;
        end
        P_WR: if (acc_w) begin
          mem[n_wr] = avl_wdata;
          n_wr++;
          if (n_wr == N) ph = P_RD;
        end
        P_RD: begin
          ret = avl_rdata_valid && (outst > 0);
          if (ret) begin
            if (avl_rdata != pat(24'(n_ret))) begin
              if (m_err == 16'd0) m_first = 24'(n_ret);
              if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            end
            n_ret++;
          end
          if (outst > 0 && !ret) idle_run++;
          else                   idle_run = 0;
          outst = outst + int'(acc_r) - int'(ret);
          if (acc_r) begin
            q.push_back({32'(cyc + LAT), mem[n_rd] ^ mask[n_rd]});
            n_rd++;
          end
          if (idle_run == TMO) begin
            m_to = 1; m_done = 1; ph = P_DONE; q.delete();
          end else if (n_rd == N && outst == 0) begin
            m_done = 1; ph = P_DONE;
          end
        end
        P_DONE: ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic run(input int sp, input bit nr, input bit sr, output int lat);
    stall_pct = sp; noret = nr; spur = sr;
    bb_cnt = 0; wr_acc_cnt = 0; rd_acc_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
    check("done_reached", 64'(done), 64'd1);
    tick();
    tick();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : control
    int lat, k, nerr;
    logic [23:0] first;
    for (int i = 0; i < N; i++) mask[i] = 64'd0;
    repeat (3) @(posedge CLK);
    #2;
    check("reset_flags", 64'({avl_burstbegin, avl_write_req, avl_read_req, busy,
                              done, pass, cal_fail, timeout}), 64'd0);
    check("reset_addr", 64'(avl_addr), 64'd0);
    check("reset_wdata", avl_wdata, 64'd0);
    check("reset_err", 64'({err_count, first_err_addr}), 64'd0);
    check("pattern_pin", pat(24'd5), 64'hA5000005_5AFFFFFA);
    nRST = 1'b1;
    tick();

    // Ideal memory, no stalls.
    run(0, 0, 0, lat);
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_err", 64'(err_count), 64'd0);
    check("t1_latency_le_40", 64'(lat <= 40), 64'd1);
    check("t1_writes", 64'(wr_acc_cnt), 64'd16);
    check("t1_reads", 64'(rd_acc_cnt), 64'd16);

    // 30% stalls with stray strobes, started straight after the previous run.
    run(30, 0, 1, lat);
    check("t2_burstbegin_count", 64'(bb_cnt), 64'd32);
    check("t2_pass", 64'(pass), 64'd1);

    // Corrupted words at 5 and 9.
    mask[5] = 64'd1; mask[9] = 64'd1;
    run(30, 0, 0, lat);
    check("t3_err", 64'(err_count), 64'd2);
    check("t3_first", 64'(first_err_addr), 64'd5);
    check("t3_pass", 64'(pass), 64'd0);
    mask[5] = 64'd0; mask[9] = 64'd0;

    // Calibration failure.
    local_init_done = 1'b0; local_cal_success = 1'b0; local_cal_fail = 1'b1;
    run(0, 0, 0, lat);
    check("t4_cal_fail", 64'(cal_fail), 64'd1);
    check("t4_done", 64'(done), 64'd1);
    check("t4_pass", 64'(pass), 64'd0);
    check("t4_no_cmds", 64'(wr_acc_cnt + rd_acc_cnt + bb_cnt), 64'd0);
    local_init_done = 1'b1; local_cal_success = 1'b1; local_cal_fail = 1'b0;

    // Memory never returns read data.
    run(0, 1, 0, lat);
    check("t5_timeout", 64'(timeout), 64'd1);
    check("t5_pass", 64'(pass), 64'd0);
    check("t5_reads_le_max", 64'(rd_acc_cnt > 0 && rd_acc_cnt <= MAXO), 64'd1);
    noret = 1'b0;

    // Reset in the middle of the read phase.
    stall_pct = 0; rd_acc_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (rd_acc_cnt < 3 && k < 100) begin
      tick();
      k++;
    end
    check("t6_reached_read", 64'(rd_acc_cnt >= 3), 64'd1);
    nRST = 1'b0;
    #1;
    check("t6_reset_flags", 64'({avl_burstbegin, avl_write_req, avl_read_req, busy,
                                 done, pass, cal_fail, timeout}), 64'd0);
    check("t6_reset_addr", 64'(avl_addr), 64'd0);
    check("t6_reset_wdata", avl_wdata, 64'd0);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    run(0, 0, 0, lat);
    check("t6_pass_after_reset", 64'(pass), 64'd1);

    // Randomised stall rates and corruption sets.
    for (int it = 0; it < 4; it++) begin
      nerr = 0; first = 24'd0;
      for (int a = 0; a < N; a++) begin
        mask[a] = ($urandom_range(99) < 20) ? (64'd1 << $urandom_range(63)) : 64'd0;
        if (mask[a] != 64'd0) begin
          if (nerr == 0) first = 24'(a);
          nerr++;
        end
      end
      run(int'($urandom_range(40)), 0, 1, lat);
      check("rand_err", 64'(err_count), 64'(nerr));
      check("rand_first", 64'(first_err_addr), 64'(first));
      check("rand_pass", 64'(pass), 64'(nerr == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr2_avl_memtest.md
# ddr2_avl_memtest

Avalon-MM traffic sequencer that sits directly upstream of the DDR2 UniPHY master on its `avl_*` user port. It is clocked in the `afi_clk` domain. The block waits for PHY calibration, writes a deterministic address-derived pattern over a programmable word range, and reads the range back in order, comparing every word. It reports busy/done/pass, a saturating error count, the first failing address, and calibration-fail/timeout flags for board bring-up.

## Interface
- `START_ADDR`, default 24'h000000: first word address tested.
- `END_ADDR`, default 24'h000FFF: last word address tested, inclusive; must be ≥ `START_ADDR`.
- `MAX_OUTST`, default 8: maximum reads accepted but not yet returned; range 1..15.
- `TIMEOUT`, default 4096: cycles allowed without `avl_rdata_valid` while reads are outstanding.

Ports:
- `CLK` in 1: the AFI clock, connected to the IP's `afi_clk`.
- `nRST` in 1: asynchronous active-low reset. Tie to `afi_reset_n`.
- `start` in 1: single-cycle pulse that starts a test. Ignored while `busy`.
- `local_init_done`, `local_cal_success`, `local_cal_fail` in 1 each: IP status.
- `avl_ready` in 1: Avalon waitrequest_n.
- `avl_burstbegin` out 1: beginbursttransfer.
- `avl_addr` out 24: word address.
- `avl_write_req` out 1, `avl_read_req` out 1: command strobes.
- `avl_wdata` out 64: write data.
- `avl_size` out 1: burst count, constant 1'b1.
- `avl_rdata_valid` in 1, `avl_rdata` in 64: read return data, delivered in order.
- `busy` out 1: high from the start pulse until DONE.
- `done` out 1: sticky; cleared by the next accepted `start`.
- `pass` out 1: valid when `done` is high.
- `err_count` out 16: saturating mismatch count.
- `first_err_addr` out 24: address of the first mismatch.
- `cal_fail` out 1: calibration failed during this test.
- `timeout` out 1: read-return timeout occurred during this test.

## Operation
- Pattern for word address a: `P(a) = {8'hA5, a, ~{8'hA5, a}}`, 64 bits.
- States: IDLE, WAIT_CAL, WRITE, READ, DRAIN, DONE.
- **IDLE**
  - On `start`: clear `done`, `pass`, `err_count`, `first_err_addr`, `cal_fail`, `timeout`.
  - Load the write, read-issue and check counters with `START_ADDR`.
  - Go to WAIT_CAL.
- **WAIT_CAL**
  - If `local_cal_fail`: set `cal_fail` and go to DONE.
  - Else if `local_init_done && local_cal_success`: go to WRITE.
- **WRITE**
  - Present `avl_write_req=1`, `avl_addr=wa`, `avl_wdata=P(wa)`.
  - Hold all command outputs stable while `avl_ready=0`.
  - A write is accepted in a cycle with req && `avl_ready`; then wa increments.
  - On acceptance of `END_ADDR`: deassert the request and go to READ.
- **READ**
  - Present `avl_read_req=1`, `avl_addr=ra` whenever outstanding < `MAX_OUTST`.
  - A read is accepted with req && `avl_ready`; outstanding +1, ra +1.
  - Each `avl_rdata_valid`: outstanding −1; compare `avl_rdata` against `P(ca)`; ca +1.
  - On mismatch:
    - `err_count` +1, saturating at 16'hFFFF.
    - If this is the first error, capture `first_err_addr=ca`.
  - An accept and a return in the same cycle leave outstanding unchanged.
  - After the read at `END_ADDR` is accepted: go to DRAIN.
- **DRAIN**
  - Issue no new commands.
  - Continue checking returns until outstanding = 0, then go to DONE.
- **Timeout**
  - Counter resets on every `avl_rdata_valid`, and whenever outstanding = 0.
  - Counts in READ and DRAIN while outstanding > 0.
  - Reaching `TIMEOUT`: set `timeout`, go to DONE. Remaining returns are ignored.
- **DONE**
  - For one cycle: `busy=0`, `done=1`, `pass = (err_count==0) && !cal_fail && !timeout`.
  - Return to IDLE; `done` and the result outputs hold.
- `avl_burstbegin` is high only in the first cycle each new command is presented, never during a held (waiting) cycle.
- Address arithmetic is 24-bit. `END_ADDR=24'hFFFFFF` must terminate without wrapping the compare.
- Unexpected `avl_rdata_valid` with outstanding = 0 is ignored and not counted.

## Timing
- All outputs reset to 0, including `avl_*` strobes and `avl_addr`/`avl_wdata`. `avl_size` is 1.
- `start` at cycle N:
  - `busy=1` and state WAIT_CAL at N+1.
  - With calibration already good: first write presented at N+2.
- With `avl_ready` held high:
  - One write per cycle.
  - One read per cycle until outstanding reaches `MAX_OUTST`.
- WRITE→READ adds no idle cycle: the first read is presented in the cycle after the last write is accepted.
- Compare result registers update one cycle after `avl_rdata_valid`.
- `done` asserts one cycle after the last check.
- If `nRST` asserts mid-test, all state clears immediately and every command strobe drops asynchronously.

## Test plan
- Ideal memory model with `avl_ready=1` and 3-cycle read latency, `START_ADDR=0`, `END_ADDR=15`:
  - Expect 16 writes, then 16 reads.
  - `pass=1`, `err_count=0`.
  - `done` within 40 cycles of `start`.
- Random `avl_ready` stalls at 30%:
  - Command outputs stay stable during stalls.
  - `avl_burstbegin` pulses exactly 32 times.
  - `pass=1`.
- Model corrupts bit 0 of the words at addresses 5 and 9 → `err_count=2`, `first_err_addr=5`, `pass=0`.
- `local_cal_fail=1` during WAIT_CAL → no commands issued, `cal_fail=1`, `done=1`, `pass=0`.
- Model never returns read data, `TIMEOUT=64` → at most `MAX_OUTST`=8 reads issued, `timeout=1`, `pass=0`.
- `nRST` pulsed during READ:
  - All outputs return to 0.
  - A subsequent `start` completes with `pass=1`.
